// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: RISC-V decode stage with register file, write-back bypass,
// immediate generation, illegal-opcode flagging and a D/E pipeline register.
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   instr_i, pc_i,
//   pc_plus4_i, valid_i     instruction in decode, its PC, PC+4, and valid flag
//   stall_i, flush_i        hazard-unit controls; flush wins over stall
//   wb_we_i, wb_rd_i,
//   wb_data_i               write-back port into the register file
//   valid_o ... illegal_o   registered D/E fields (one cycle after the inputs)
module decode_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic            valid_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            wb_we_i,
    input  logic [AW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            valid_o,
    output logic [6:0]      op_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [AW-1:0]   rs1_o,
    output logic [AW-1:0]   rs2_o,
    output logic [AW-1:0]   rd_o,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            illegal_o
);
    logic [XLEN-1:0] regs [NREG];
    logic [6:0]      op;
    logic [AW-1:0]   rs1, rs2, rd;
    logic            wb_hit;
    logic [XLEN-1:0] rd1, rd2, imm;
    logic [31:0]     imm32;
    logic            is_i, is_s, is_b, is_u, is_j, is_r, illegal;

    assign op     = instr_i[6:0];
    assign rs1    = instr_i[15 +: AW];
    assign rs2    = instr_i[20 +: AW];
    assign rd     = instr_i[7 +: AW];
    assign wb_hit = wb_we_i && wb_rd_i != '0;

    // x0 is never written, so its entry stays 0 and needs no read guard
    assign rd1 = (wb_hit && wb_rd_i == rs1) ? wb_data_i : regs[rs1];
    assign rd2 = (wb_hit && wb_rd_i == rs2) ? wb_data_i : regs[rs2];

    assign is_i = op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111 || op == 7'b1110011;
    assign is_s = op == 7'b0100011;
    assign is_b = op == 7'b1100011;
    assign is_u = op == 7'b0110111 || op == 7'b0010111;
    assign is_j = op == 7'b1101111;
    assign is_r = op == 7'b0110011;
    assign illegal = !(is_i || is_s || is_b || is_u || is_j || is_r);

    assign imm32 = is_i ? {{20{instr_i[31]}}, instr_i[31:20]} :
                   is_s ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
                   is_b ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
                   is_u ? {instr_i[31:12], 12'b0} :
                   is_j ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
                   32'b0;
    // signed cast so the 32-bit immediate sign-extends when XLEN is 64
    assign imm = XLEN'(signed'(imm32));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_hit) begin
            regs[wb_rd_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o    <= 1'b0;
            op_o       <= '0;
            funct3_o   <= '0;
            funct7_o   <= '0;
            rs1_o      <= '0;
            rs2_o      <= '0;
            rd_o       <= '0;
            rd1_o      <= '0;
            rd2_o      <= '0;
            imm_o      <= '0;
            pc_o       <= '0;
            pc_plus4_o <= '0;
            illegal_o  <= 1'b0;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
            op_o       <= '0;
            funct3_o   <= '0;
            funct7_o   <= '0;
            rs1_o      <= '0;
            rs2_o      <= '0;
            rd_o       <= '0;
            rd1_o      <= '0;
            rd2_o      <= '0;
            imm_o      <= '0;
            pc_o       <= '0;
            pc_plus4_o <= '0;
            illegal_o  <= 1'b0;
        end else if (stall_i) begin
            // refresh held operands so a write-back during the stall is not lost
            if (wb_hit && wb_rd_i == rs1_o) rd1_o <= wb_data_i;
            if (wb_hit && wb_rd_i == rs2_o) rd2_o <= wb_data_i;
        end else begin
            valid_o    <= valid_i;
            op_o       <= op;
            funct3_o   <= instr_i[14:12];
            funct7_o   <= instr_i[31:25];
            rs1_o      <= rs1;
            rs2_o      <= rs2;
            rd_o       <= rd;
            rd1_o      <= rd1;
            rd2_o      <= rd2;
            imm_o      <= imm;
            pc_o       <= pc_i;
            pc_plus4_o <= pc_plus4_i;
            illegal_o  <= valid_i && illegal;
        end
    end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised RISC-V instruction-decode stage with an integrated D/E pipeline register. It contains the register file with same-cycle write-back bypass, immediate generation for all base formats, and illegal-opcode flagging. It accepts stall and flush from the hazard unit. The block sits between the fetch/decode boundary and the execute stage.

Parameters:
XLEN, 32, datapath width (32 or 64); immediates sign-extended to XLEN
NREG, 32, number of architectural registers (16 or 32)
AW, $clog2(NREG), register index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_i  in  32  instruction in decode
pc_i  in  XLEN  PC of instr_i
pc_plus4_i  in  XLEN  PC+4 of instr_i
valid_i  in  1  instr_i is a real instruction (0 = bubble)
stall_i  in  1  hold the D/E register
flush_i  in  1  squash the D/E register (wins over stall_i)
wb_we_i  in  1  write-back enable
wb_rd_i  in  AW  write-back register index
wb_data_i  in  XLEN  write-back data
valid_o  out  1  D/E entry valid
op_o  out  7  opcode
funct3_o  out  3  funct3
funct7_o  out  7  funct7
rs1_o, rs2_o, rd_o  out  AW each  register indices
rd1_o, rd2_o  out  XLEN each  source operand values
imm_o  out  XLEN  extended immediate
pc_o, pc_plus4_o  out  XLEN each  registered PC values
illegal_o  out  1  unknown opcode on a valid entry

Behaviour:
- Reset (rst_n=0, async): every output is 0 and every register-file entry is 0. The D/E register loads on the first rising edge after deassertion.
- Register file:
  - Write on the rising edge when wb_we_i=1 and wb_rd_i!=0.
  - A write to x0 is ignored; x0 always reads 0.
  - Indices >= NREG are ignored on write and read 0.
- Read path is combinational, from instr_i[19:15] and instr_i[24:20] truncated to AW.
- Bypass: if wb_we_i=1, wb_rd_i!=0 and wb_rd_i equals a source index, that read returns wb_data_i in the same cycle.
- Immediate by opcode (instr_i[6:0]):
  - I-type: 0000011, 0010011, 1100111, 1110011 -> instr[31:20]
  - S-type: 0100011 -> {instr[31:25], instr[11:7]}
  - B-type: 1100011 -> {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U-type: 0110111, 0010111 -> {instr[31:12], 12'b0}
  - J-type: 1101111 -> {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R-type: 0110011 -> 0
  - Any other opcode -> imm 0 and illegal=1
  - Every result is sign-extended from its top bit to XLEN.
- D/E register update on each rising edge, in priority order:
  1. flush_i=1: valid_o=0, illegal_o=0, all other outputs 0.
  2. stall_i=1: all fields hold, except the operand refresh below.
  3. Otherwise: all fields load from the decode of the current inputs. illegal_o = valid_i & illegal. When valid_i=0, all fields still load but valid_o=0 and illegal_o=0.
- Stall refresh: while stall_i=1 and flush_i=0, if a write-back hits rs1_o (wb_we_i=1, wb_rd_i=rs1_o, rs1_o!=0), rd1_o loads wb_data_i at that edge. The same rule applies to rs2_o/rd2_o. This keeps held operands from going stale.
- Latency: exactly one cycle from inputs to outputs. There is no combinational path from inputs to outputs.
- Reset asserted mid-stall or mid-flush: outputs clear immediately; register-file contents clear.

Test Plan:
1. Reset, then valid_i=1, instr_i=0x00500093 (addi x1,x0,5), pc_i=0x100 -> next cycle: valid_o=1, op_o=0x13, rd_o=1, imm_o=5, pc_o=0x100, rd1_o=0, illegal_o=0.
2. Bypass: wb_we_i=1, wb_rd_i=3, wb_data_i=0xDEADBEEF in the same cycle as instr_i=0x00318133 (add x2,x3,x3) -> next cycle rd1_o=rd2_o=0xDEADBEEF. Repeat with wb_rd_i=0 -> rd1_o=rd2_o=0.
3. Immediates: instr 0xFE000EE3 (beq x0,x0,-4) -> imm_o=0xFFFFFFFC. instr 0x800000EF (jal x1,-1MiB) -> imm_o=0xFFF00000. With XLEN=64, the same beq -> 0xFFFFFFFFFFFFFFFC.
4. Stall with refresh: decode an add with rs1=5, then stall_i=1 for 3 cycles while inputs change. In stall cycle 2, write x5=0x1234 -> all fields hold throughout, except rd1_o, which becomes 0x1234 after that edge.
5. Flush beats stall: stall_i=1 and flush_i=1 together -> valid_o=0, imm_o=0, pc_o=0 next cycle. Also: valid_i=1 with opcode 0x7F -> illegal_o=1, imm_o=0. valid_i=0 with the same opcode -> illegal_o=0.
6. Async reset mid-operation: pull rst_n low between clock edges -> outputs read 0 before the next edge. After release, reads of x1 return 0.
